// File: rtl/seq_rca_pkg.sv
// Shared definitions for the sequential ripple-carry adder.
//   state_t    : FSM state encoding (IDLE, RUN, DONE)
//   nseg_of    : number of segments for a given width / segment size
//   cnt_width  : segment counter width, $clog2(nseg) with a floor of 1
package seq_rca_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int unsigned nseg_of(input int unsigned width,
                                            input int unsigned seg);
        return width / seg;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned nseg);
        return (nseg > 1) ? $clog2(nseg) : 1;
    endfunction

endpackage

// File: rtl/rca_seg.sv
// Combinational SEG-bit ripple-carry adder used for one segment per cycle.
//   x, y : SEG-bit operands
//   cin  : carry in
//   s    : SEG-bit sum
//   cout : carry out of the top bit
module rca_seg #(
    parameter int unsigned SEG = 4
) (
    input  logic [SEG-1:0] x,
    input  logic [SEG-1:0] y,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);

    logic c;

    always_comb begin
        s = '0;
        c = cin;
        for (int unsigned i = 0; i < SEG; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/seq_rca_adder.sv
// Multi-cycle adder: adds SEG bits per clock over NSEG = WIDTH/SEG cycles.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : begin an addition (accepted in IDLE or DONE)
//   x, y  : WIDTH-bit operands, captured on the accepting edge
//   cin   : carry in, captured on the accepting edge
//   s     : registered WIDTH-bit sum
//   cout  : registered carry out
//   busy  : high while in RUN
//   done  : one-cycle pulse when s/cout hold a new result
module seq_rca_adder
    import seq_rca_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NSEG = nseg_of(WIDTH, SEG);
    localparam int unsigned CW   = cnt_width(NSEG);

    if (WIDTH % SEG != 0) begin : g_bad_seg
        $error("WIDTH must be a multiple of SEG");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xo_q, xo_d;
    logic [WIDTH-1:0] yo_q, yo_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;

    logic [SEG-1:0]   seg_s;
    logic             seg_cout;

    // Captured operands shift right each RUN cycle, so the current
    // segment k always sits in the low SEG bits.
    rca_seg #(
        .SEG(SEG)
    ) u_seg (
        .x   (xo_q[SEG-1:0]),
        .y   (yo_q[SEG-1:0]),
        .cin (carry_q),
        .s   (seg_s),
        .cout(seg_cout)
    );

    always_comb begin
        state_d = state_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    xo_d    = x;
                    yo_d    = y;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                xo_d    = xo_q >> SEG;
                yo_d    = yo_q >> SEG;
                // New segment enters at the top; after NSEG cycles segment 0
                // has shifted down to bit 0.
                acc_d   = (acc_q >> SEG) | (WIDTH'(seg_s) << (WIDTH - SEG));
                carry_d = seg_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(NSEG - 1)) begin
                    s_d     = acc_d;
                    cout_d  = seg_cout;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            xo_q    <= '0;
            yo_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule
